// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the SSM2603 codec configuration sequencer.
//   cfg_entry_t        : one register-initialisation step (delay flag, address, data)
//   INIT_TABLE         : power-up register sequence replayed after every (re)start
//   codec_cfg_state_e  : sequencer FSM states
//   SHADOW_DEPTH/_AW   : geometry of the optional register shadow (CODEC_SHADOW_EN)
package codec_cfg_pkg;

  typedef struct packed {
    logic       dly;   // wait the codec activation delay before this write
    logic [6:0] addr;
    logic [8:0] data;
  } cfg_entry_t;

  localparam int INIT_LEN = 11;
  localparam int IDX_W    = $clog2(INIT_LEN);

  // R6 is written twice: first to power the blocks up with the outputs still
  // off, then (after the activation delay on R9) to enable the outputs.
  localparam cfg_entry_t INIT_TABLE [INIT_LEN] = '{
    '{1'b0, 7'd15, 9'h000},  // R15 reset
    '{1'b0, 7'd6,  9'h072},  // R6  power management, outputs off
    '{1'b0, 7'd0,  9'h017},  // R0  left line in
    '{1'b0, 7'd1,  9'h017},  // R1  right line in
    '{1'b0, 7'd2,  9'h079},  // R2  left headphone out
    '{1'b0, 7'd3,  9'h079},  // R3  right headphone out
    '{1'b0, 7'd4,  9'h012},  // R4  analogue path
    '{1'b0, 7'd5,  9'h000},  // R5  digital path
    '{1'b0, 7'd7,  9'h002},  // R7  digital audio interface
    '{1'b1, 7'd9,  9'h001},  // R9  activate
    '{1'b0, 7'd6,  9'h062}   // R6  outputs on
  };

  localparam int SHADOW_DEPTH = 16;
  localparam int SHADOW_AW    = $clog2(SHADOW_DEPTH);

  typedef enum logic [2:0] {
    ST_RST,
    ST_INIT_DLY,
    ST_INIT_ISSUE,
    ST_INIT_WAIT,
    ST_READY,
    ST_HOST_ISSUE,
    ST_HOST_WAIT,
    ST_ERROR
  } codec_cfg_state_e;

endpackage

// File: rtl/codec_cfg_shadow.sv
// Register shadow for the codec: a small array holding the last value written
// (and acknowledged) to each of the low codec registers, so host reads of them
// need no I2C traffic. Only instantiated when CODEC_SHADOW_EN is defined.
//   clk, rst_n        : clock, asynchronous active-low reset (array clears to 0)
//   wr_en/addr/data   : write port
//   rd_addr, rd_data  : asynchronous read port
module codec_cfg_shadow
  import codec_cfg_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [SHADOW_AW-1:0] wr_addr,
  input  logic [8:0]           wr_data,
  input  logic [SHADOW_AW-1:0] rd_addr,
  output logic [8:0]           rd_data
);

  logic [8:0] mem_q [SHADOW_DEPTH];

  // NOTE: this array is reset because a read of a never-written register must
  // return 0; arrays without that need are better left unreset (plain RAM).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SHADOW_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Codec configuration sequencer: owns the single I2C register-access path to
// the SSM2603. After reset (or start_init) it replays INIT_TABLE, retrying
// NACKed writes up to MAX_RETRY times and inserting ACT_DLY_CYC idle cycles
// before entries flagged dly; afterwards it serves host register accesses.
// Optional macro CODEC_SHADOW_EN adds a 16-entry register shadow that serves
// host reads of addresses 0..15 without I2C traffic.
// Ports:
//   s00_axi_aclk, s00_axi_aresetn : clock, asynchronous active-low reset
//   start_init                    : pulse, (re)run init table (RST/READY/ERROR)
//   host_req/rnw/addr/wdata       : host access request (sampled in READY)
//   host_gnt, host_done           : accept / completion pulses
//   host_rdata, host_err          : result, valid with host_done
//   i2c_req/rnw/addr/wdata        : request to the I2C controller
//   i2c_ready/done/nack/rdata     : handshake and result from the controller
//   init_done, init_error         : init sequence status
//   missed_ack                    : sticky, any NACK since the last (re)start
//   controller_busy               : high outside READY and ERROR
module codec_cfg_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int unsigned MAX_RETRY   = 3,
  parameter logic [15:0] ACT_DLY_CYC = 16'd50000,
  parameter bit          AUTO_INIT   = 1'b1
) (
  input  logic       s00_axi_aclk,
  input  logic       s00_axi_aresetn,
  input  logic       start_init,
  input  logic       host_req,
  input  logic       host_rnw,
  input  logic [6:0] host_addr,
  input  logic [8:0] host_wdata,
  output logic       host_gnt,
  output logic       host_done,
  output logic [8:0] host_rdata,
  output logic       host_err,
  output logic       i2c_req,
  output logic       i2c_rnw,
  output logic [6:0] i2c_addr,
  output logic [8:0] i2c_wdata,
  input  logic       i2c_ready,
  input  logic       i2c_done,
  input  logic       i2c_nack,
  input  logic [8:0] i2c_rdata,
  output logic       init_done,
  output logic       init_error,
  output logic       missed_ack,
  output logic       controller_busy
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  codec_cfg_state_e     state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [15:0]          dly_cnt_q, dly_cnt_d;
  logic                 cap_rnw_q, cap_rnw_d;
  logic [6:0]           cap_addr_q, cap_addr_d;
  logic [8:0]           cap_wdata_q, cap_wdata_d;
  logic                 shadow_rd_q, shadow_rd_d;
  logic                 init_done_q, init_done_d;
  logic                 init_error_q, init_error_d;
  logic                 missed_ack_q, missed_ack_d;
  logic                 busy_q, busy_d;
  logic                 host_done_q, host_done_d;
  logic                 host_err_q, host_err_d;
  logic [8:0]           host_rdata_q, host_rdata_d;

  cfg_entry_t cur_entry;
  logic       dly_done;
  logic       start_seq;
  logic       shadow_hit;
  logic [8:0] shadow_rdata;

  assign cur_entry = INIT_TABLE[idx_q];
  // Widened so ACT_DLY_CYC = 0 still yields the mandatory single cycle.
  assign dly_done  = ({1'b0, dly_cnt_q} + 17'd1) >= {1'b0, ACT_DLY_CYC};

`ifdef CODEC_SHADOW_EN
  logic       init_wr_ack, host_wr_ack, shadow_we;
  logic [6:0] shadow_waddr;
  logic [8:0] shadow_wdata;

  assign init_wr_ack  = (state_q == ST_INIT_WAIT) && i2c_done && !i2c_nack;
  assign host_wr_ack  = (state_q == ST_HOST_WAIT) && !shadow_rd_q && !cap_rnw_q &&
                        i2c_done && !i2c_nack;
  assign shadow_waddr = init_wr_ack ? cur_entry.addr : cap_addr_q;
  assign shadow_wdata = init_wr_ack ? cur_entry.data : cap_wdata_q;
  assign shadow_we    = (init_wr_ack || host_wr_ack) && (shadow_waddr < 7'd16);
  assign shadow_hit   = host_rnw && (host_addr < 7'd16);

  codec_cfg_shadow u_shadow (
    .clk     (s00_axi_aclk),
    .rst_n   (s00_axi_aresetn),
    .wr_en   (shadow_we),
    .wr_addr (shadow_waddr[SHADOW_AW-1:0]),
    .wr_data (shadow_wdata),
    .rd_addr (cap_addr_q[SHADOW_AW-1:0]),
    .rd_data (shadow_rdata)
  );
`else
  assign shadow_hit   = 1'b0;
  assign shadow_rdata = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q      <= ST_RST;
      idx_q        <= '0;
      retry_q      <= '0;
      dly_cnt_q    <= '0;
      cap_rnw_q    <= 1'b0;
      cap_addr_q   <= '0;
      cap_wdata_q  <= '0;
      shadow_rd_q  <= 1'b0;
      init_done_q  <= 1'b0;
      init_error_q <= 1'b0;
      missed_ack_q <= 1'b0;
      busy_q       <= 1'b0;
      host_done_q  <= 1'b0;
      host_err_q   <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      retry_q      <= retry_d;
      dly_cnt_q    <= dly_cnt_d;
      cap_rnw_q    <= cap_rnw_d;
      cap_addr_q   <= cap_addr_d;
      cap_wdata_q  <= cap_wdata_d;
      shadow_rd_q  <= shadow_rd_d;
      init_done_q  <= init_done_d;
      init_error_q <= init_error_d;
      missed_ack_q <= missed_ack_d;
      busy_q       <= busy_d;
      host_done_q  <= host_done_d;
      host_err_q   <= host_err_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  // Next-state and datapath.
  // NOTE: every variable gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    retry_d      = retry_q;
    dly_cnt_d    = dly_cnt_q;
    cap_rnw_d    = cap_rnw_q;
    cap_addr_d   = cap_addr_q;
    cap_wdata_d  = cap_wdata_q;
    shadow_rd_d  = shadow_rd_q;
    init_done_d  = init_done_q;
    init_error_d = init_error_q;
    missed_ack_d = missed_ack_q;
    host_done_d  = 1'b0;
    host_err_d   = host_err_q;
    host_rdata_d = host_rdata_q;
    start_seq    = 1'b0;

    unique case (state_q)
      ST_RST:   if (AUTO_INIT || start_init) start_seq = 1'b1;
      ST_INIT_DLY: begin
        if (!cur_entry.dly || dly_done) begin
          dly_cnt_d = '0;
          state_d   = ST_INIT_ISSUE;
        end else begin
          dly_cnt_d = dly_cnt_q + 16'd1;
        end
      end
      ST_INIT_ISSUE: if (i2c_ready) state_d = ST_INIT_WAIT;
      ST_INIT_WAIT: begin
        if (i2c_done) begin
          if (!i2c_nack) begin
            retry_d = '0;
            if (idx_q == IDX_W'(INIT_LEN - 1)) begin
              init_done_d = 1'b1;   // idx stays at its terminal value
              state_d     = ST_READY;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = ST_INIT_DLY;
            end
          end else begin
            missed_ack_d = 1'b1;
            if (retry_q < RETRY_W'(MAX_RETRY)) begin
              retry_d = retry_q + 1'b1;
              state_d = ST_INIT_ISSUE;  // retry skips the activation delay
            end else begin
              init_error_d = 1'b1;
              state_d      = ST_ERROR;
            end
          end
        end
      end
      ST_READY: begin
        if (start_init) begin
          start_seq = 1'b1;
        end else if (host_req) begin
          cap_rnw_d   = host_rnw;
          cap_addr_d  = host_addr;
          cap_wdata_d = host_wdata;
          shadow_rd_d = shadow_hit;
          state_d     = shadow_hit ? ST_HOST_WAIT : ST_HOST_ISSUE;
        end
      end
      ST_HOST_ISSUE: if (i2c_ready) state_d = ST_HOST_WAIT;
      ST_HOST_WAIT: begin
        if (shadow_rd_q) begin
          host_done_d  = 1'b1;
          host_err_d   = 1'b0;
          host_rdata_d = shadow_rdata;
          shadow_rd_d  = 1'b0;
          state_d      = ST_READY;
        end else if (i2c_done) begin
          host_done_d  = 1'b1;
          host_err_d   = i2c_nack;
          host_rdata_d = cap_rnw_q ? i2c_rdata : 9'h000;
          if (i2c_nack) missed_ack_d = 1'b1;
          state_d      = ST_READY;
        end
      end
      ST_ERROR: if (start_init) start_seq = 1'b1;
      default:  state_d = ST_RST;
    endcase

    if (start_seq) begin
      state_d      = ST_INIT_DLY;
      idx_d        = '0;
      retry_d      = '0;
      dly_cnt_d    = '0;
      init_done_d  = 1'b0;
      init_error_d = 1'b0;
      missed_ack_d = 1'b0;
    end

    // Registered so it reads 0 while reset is asserted, yet tracks the state.
    busy_d = (state_d != ST_READY) && (state_d != ST_ERROR);
  end

  // Outputs decoded from the current state.
  always_comb begin
    i2c_req   = 1'b0;
    i2c_rnw   = 1'b0;
    i2c_addr  = '0;
    i2c_wdata = '0;
    host_gnt  = 1'b0;
    unique case (state_q)
      ST_INIT_ISSUE: begin
        i2c_req   = 1'b1;
        i2c_addr  = cur_entry.addr;
        i2c_wdata = cur_entry.data;
      end
      ST_HOST_ISSUE: begin
        i2c_req   = 1'b1;
        i2c_rnw   = cap_rnw_q;
        i2c_addr  = cap_addr_q;
        i2c_wdata = cap_wdata_q;
      end
      ST_READY: host_gnt = host_req && !start_init;
      default: ;
    endcase
  end

  assign host_done       = host_done_q;
  assign host_err        = host_err_q;
  assign host_rdata      = host_rdata_q;
  assign init_done       = init_done_q;
  assign init_error      = init_error_q;
  assign missed_ack      = missed_ack_q;
  assign controller_busy = busy_q;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Self-checking bench for codec_cfg_sequencer. The bench acts as the I2C
// controller; all stimulus and sampling happen on the falling clock edge.
// ACT_DLY_CYC is shortened to 20 to keep runs short. Shadow-specific
// expectations follow CODEC_SHADOW_EN.
module tb_codec_cfg_sequencer;

  localparam logic [15:0] DLY = 16'd20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_init = 1'b0;
  logic       host_req = 1'b0, host_rnw = 1'b0;
  logic [6:0] host_addr = '0;
  logic [8:0] host_wdata = '0;
  logic       host_gnt, host_done, host_err;
  logic [8:0] host_rdata;
  logic       i2c_req, i2c_rnw;
  logic [6:0] i2c_addr;
  logic [8:0] i2c_wdata;
  logic       i2c_ready = 1'b1, i2c_done = 1'b0, i2c_nack = 1'b0;
  logic [8:0] i2c_rdata = '0;
  logic       init_done, init_error, missed_ack, controller_busy;

  always #5 clk = ~clk;

  codec_cfg_sequencer #(.MAX_RETRY(3), .ACT_DLY_CYC(DLY), .AUTO_INIT(1'b1)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .start_init(start_init),
    .host_req(host_req), .host_rnw(host_rnw), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_done(host_done),
    .host_rdata(host_rdata), .host_err(host_err), .i2c_req(i2c_req),
    .i2c_rnw(i2c_rnw), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
    .i2c_ready(i2c_ready), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
    .i2c_rdata(i2c_rdata), .init_done(init_done), .init_error(init_error),
    .missed_ack(missed_ack), .controller_busy(controller_busy)
  );

  // Expected write sequence and idle (req-low) cycles before each write.
  typedef struct {
    logic [6:0] addr;
    logic [8:0] data;
    int         idle;
  } init_vec_t;

  init_vec_t init_vec [11];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Wait (bounded) for i2c_req, optionally stall it with i2c_ready low, accept
  // it, then answer with one i2c_done pulse. Returns at the falling edge after
  // the done pulse with the done inputs cleared.
  task automatic serve(input logic nack, input logic [8:0] rd, input int stall,
                       output logic rnw, output logic [6:0] a, output logic [8:0] d,
                       output int idle);
    bit seen = 1'b0;
    idle = 0;
    rnw = 1'b0; a = '0; d = '0;
    for (int i = 0; i < 200; i++) begin
      if (i2c_req) begin
        seen = 1'b1;
        break;
      end
      idle++;
      @(negedge clk);
    end
    check("i2c_req_seen", {31'd0, seen}, 1);
    if (!seen) return;
    rnw = i2c_rnw; a = i2c_addr; d = i2c_wdata;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("req_held_stall", i2c_req, 1);
    end
    i2c_ready = 1'b1;
    @(negedge clk);
    check("req_dropped_after_accept", i2c_req, 0);
    i2c_done = 1'b1; i2c_nack = nack; i2c_rdata = rd;
    @(negedge clk);
    i2c_done = 1'b0; i2c_nack = 1'b0; i2c_rdata = '0;
  endtask

  // Serve the init table in order, NACKing entry 2 (R0) r0_nacks times first.
  // Stops after the fourth NACK, where the sequencer must give up.
  task automatic run_seq(input int first_idle, input string tag, input int r0_nacks);
    logic rnw; logic [6:0] a; logic [8:0] d; int idle;
    for (int i = 0; i < 11; i++) begin
      int tries = (i == 2) ? r0_nacks : 0;
      for (int k = 0; k <= tries && k < 4; k++) begin
        serve(k < tries, 9'h000, 0, rnw, a, d, idle);
        check($sformatf("%s_addr[%0d.%0d]", tag, i, k), {25'd0, a}, {25'd0, init_vec[i].addr});
        check($sformatf("%s_data[%0d.%0d]", tag, i, k), {23'd0, d}, {23'd0, init_vec[i].data});
        check($sformatf("%s_rnw[%0d.%0d]", tag, i, k), rnw, 0);
        check($sformatf("%s_idle[%0d.%0d]", tag, i, k), idle,
              (k > 0) ? 0 : ((i == 0) ? first_idle : init_vec[i].idle));
      end
      if (tries > 3) return;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start_init = 1'b0; host_req = 1'b0; i2c_ready = 1'b1;
    i2c_done = 1'b0; i2c_nack = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start_init = 1'b1;
    @(negedge clk);
    start_init = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic rnw; logic [6:0] a; logic [8:0] d; int idle;
    int gnt_cnt, req_cnt;

    init_vec = '{
      '{7'd15, 9'h000, 1}, '{7'd6, 9'h072, 1}, '{7'd0, 9'h017, 1},
      '{7'd1,  9'h017, 1}, '{7'd2, 9'h079, 1}, '{7'd3, 9'h079, 1},
      '{7'd4,  9'h012, 1}, '{7'd5, 9'h000, 1}, '{7'd7, 9'h002, 1},
      '{7'd9,  9'h001, int'(DLY)}, '{7'd6, 9'h062, 1}
    };

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_i2c_req", i2c_req, 0);
    check("rst_host_gnt", host_gnt, 0);
    check("rst_host_done", host_done, 0);
    check("rst_host_rdata", host_rdata, 0);
    check("rst_host_err", host_err, 0);
    check("rst_status", {init_done, init_error, missed_ack, controller_busy}, 4'b0000);

    // Plain init after reset release, everything ACKed.
    do_reset();
    run_seq(2, "init", 0);
    check("init_done", init_done, 1);
    check("init_busy", controller_busy, 0);
    check("init_error", init_error, 0);
    check("init_missed_ack", missed_ack, 0);

    // Host write with a stalled controller.
    i2c_ready = 1'b0;
    host_req = 1'b1; host_rnw = 1'b0; host_addr = 7'd4; host_wdata = 9'h015;
    #1 check("wr_gnt", host_gnt, 1);
    @(negedge clk);
    host_req = 1'b0;
    check("wr_gnt_pulse", host_gnt, 0);
    check("wr_busy", controller_busy, 1);
    serve(1'b0, 9'h1AA, 3, rnw, a, d, idle);
    check("wr_i2c_fields", {rnw, a, d}, {1'b0, 7'd4, 9'h015});
    check("wr_done", host_done, 1);
    check("wr_result", {host_err, host_rdata}, {1'b0, 9'h000});
    @(negedge clk);
    check("wr_done_pulse", host_done, 0);

    // Host read of addr 4.
    host_req = 1'b1; host_rnw = 1'b1; host_addr = 7'd4; host_wdata = 9'h000;
    #1 check("rd_gnt", host_gnt, 1);
    @(negedge clk);
    host_req = 1'b0;
`ifdef CODEC_SHADOW_EN
    check("shadow_rd_no_req1", i2c_req, 0);
    check("shadow_rd_done_early", host_done, 0);
    @(negedge clk);
    check("shadow_rd_no_req2", i2c_req, 0);
    check("shadow_rd_done", host_done, 1);
    check("shadow_rd_result", {host_err, host_rdata}, {1'b0, 9'h015});
`else
    serve(1'b0, 9'h0AB, 0, rnw, a, d, idle);
    check("rd_i2c_fields", {rnw, a}, {1'b1, 7'd4});
    check("rd_done", host_done, 1);
    check("rd_result", {host_err, host_rdata}, {1'b0, 9'h0AB});
`endif
    @(negedge clk);

    // Host read above the shadow range, NACKed.
    host_req = 1'b1; host_rnw = 1'b1; host_addr = 7'h30;
    #1 check("nack_rd_gnt", host_gnt, 1);
    @(negedge clk);
    host_req = 1'b0;
    serve(1'b1, 9'h1FF, 0, rnw, a, d, idle);
    check("nack_rd_fields", {rnw, a}, {1'b1, 7'h30});
    check("nack_rd_done", host_done, 1);
    check("nack_rd_result", {host_err, host_rdata}, {1'b1, 9'h1FF});
    check("nack_rd_missed_ack", missed_ack, 1);

    // start_init and host_req together in READY: restart wins, no grant.
    @(negedge clk);
    host_req = 1'b1; host_rnw = 1'b0; host_addr = 7'd2; start_init = 1'b1;
    #1 check("restart_no_gnt", host_gnt, 0);
    @(negedge clk);
    host_req = 1'b0; start_init = 1'b0;
    check("restart_done_cleared", init_done, 0);
    check("restart_missed_cleared", missed_ack, 0);
    run_seq(1, "restart", 0);
    check("restart_init_done", init_done, 1);

    // R0 NACKed twice, then ACKed.
    do_reset();
    run_seq(2, "retry", 2);
    check("retry_missed_ack", missed_ack, 1);
    check("retry_init_done", init_done, 1);
    check("retry_init_error", init_error, 0);

    // R0 NACKed four times: give up, never issue R1, refuse the host.
    do_reset();
    run_seq(2, "err", 4);
    check("err_init_error", init_error, 1);
    check("err_init_done", init_done, 0);
    check("err_busy", controller_busy, 0);
    gnt_cnt = 0; req_cnt = 0;
    host_req = 1'b1; host_rnw = 1'b0; host_addr = 7'd5;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (host_gnt) gnt_cnt++;
      if (i2c_req) req_cnt++;
      @(negedge clk);
    end
    host_req = 1'b0;
    check("err_no_gnt", gnt_cnt, 0);
    check("err_no_req", req_cnt, 0);
    pulse_start();
    check("err_restart_cleared", {init_error, missed_ack}, 2'b00);
    run_seq(1, "err_restart", 0);
    check("err_restart_done", init_done, 1);

    // Reset during INIT_WAIT with a stale done after release.
    do_reset();
    for (int i = 0; i < 3; i++) serve(1'b0, 9'h000, 0, rnw, a, d, idle);
    gnt_cnt = 0;
    while (!i2c_req && gnt_cnt < 50) begin
      gnt_cnt++;
      @(negedge clk);
    end
    check("rst_mid_req_seen", i2c_req, 1);
    @(negedge clk);                 // accepted: now waiting for done
    rst_n = 1'b0;
    #1 check("rst_mid_req", i2c_req, 0);
    check("rst_mid_busy", controller_busy, 0);
    @(negedge clk);
    rst_n = 1'b1; i2c_done = 1'b1;  // stale completion of the abandoned write
    @(negedge clk);
    i2c_done = 1'b0;
    run_seq(1, "rst_mid", 0);
    check("rst_mid_init_done", init_done, 1);
    check("rst_mid_missed_ack", missed_ack, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
